versat_databus_arbiter: RTL and testbench
=========================================

VERSAT_DATABUS_ARBITER -- requirements
Module: versat_databus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of databus requester units (VRead/VWrite), range 2..8.
REQ-002 SHALL have parameter AXI_ADDR_W, default 32: address width per requester.
REQ-003 SHALL have parameter DATA_W, default `DATAPATH_W: data width per requester.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port databus_valid, input, N_REQ: per-requester beat valid.
REQ-007 SHALL have port databus_addr, input, N_REQ*AXI_ADDR_W: packed per-requester burst addresses, requester i at [i*AXI_ADDR_W +: AXI_ADDR_W].
REQ-008 SHALL have port databus_wdata, input, N_REQ*DATA_W: packed write data.
REQ-009 SHALL have port databus_wstrb, input, N_REQ*DATA_W/8: packed strobes; all-zero means read burst.
REQ-010 SHALL have port databus_len, input, N_REQ*8: packed burst length, beats = len+1.
REQ-011 SHALL have ports databus_ready, databus_last, output, N_REQ each: per-requester beat accept and last-beat flags.
REQ-012 SHALL have port databus_rdata, output, DATA_W: memory read data broadcast to all requesters.
REQ-013 SHALL have ports mem_valid (1), mem_addr (AXI_ADDR_W), mem_wdata (DATA_W), mem_wstrb (DATA_W/8), mem_len (8), output: single downstream memory port.
REQ-014 SHALL have ports mem_ready (1), mem_last (1), mem_rdata (DATA_W), input: downstream responses.
REQ-015 SHALL have outputs busy (1), grant_idx ($clog2(N_REQ)), len_err (1, sticky).

Function
REQ-016 SHALL implement FSM states IDLE and BURST.
REQ-017 In IDLE, SHALL select the first requester with databus_valid high, searching round-robin starting at rr_ptr, register it into grant_idx, load beat counter with databus_len[grant]+1, and enter BURST the next cycle (one-cycle arbitration latency).
REQ-018 In IDLE, mem_valid, all databus_ready and all databus_last SHALL be 0.
REQ-019 In BURST, mem_* request fields SHALL equal the granted requester's fields combinationally; mem_valid = databus_valid[grant_idx].
REQ-020 In BURST, databus_ready[grant_idx] = mem_ready and databus_last[grant_idx] = mem_last; all other bits SHALL be 0.
REQ-021 A beat is accepted when mem_valid & mem_ready; each accepted beat SHALL decrement the 9-bit beat counter.
REQ-022 An accepted beat with mem_last=1 SHALL end the burst: next state IDLE, rr_ptr = grant_idx+1 modulo N_REQ (wrap N_REQ-1 -> 0).
REQ-023 Grant SHALL be held while the granted requester deasserts valid mid-burst; no other requester is served until burst end.
REQ-024 If mem_last arrives on an accepted beat with counter != 1, or counter reaches 0 without mem_last, len_err SHALL set and stay set until rst; the burst still ends on mem_last.
REQ-025 databus_rdata SHALL equal mem_rdata at all times.
REQ-026 busy SHALL be 1 exactly in BURST.
REQ-027 Requests arriving in the cycle a burst ends SHALL be arbitrated in the following IDLE cycle; no back-to-back grant without IDLE.

Reset
REQ-028 On rst: state IDLE, rr_ptr 0, grant_idx 0, beat counter 0, len_err 0, busy 0; consequently mem_valid, databus_ready, databus_last are 0 the next cycle.
REQ-029 rst asserted mid-burst SHALL abort the burst with no further beat forwarded after the reset edge.

Structure
REQ-030 State encoding and N_REQ default SHALL live in shared package versat_pkg; widths derive from `DATAPATH_W and AXI_ADDR_W.
REQ-031 Round-robin selection SHALL be a sub-module versat_rr_arbiter (request vector, pointer in; one-hot grant and index out, combinational).

Verification
REQ-032 After reset, valid=2'b11, len 3 both, mem_ready=1, mem_last on 4th beat -> grant 0 for 4 beats, IDLE 1 cycle, then grant 1 for 4 beats; len_err=0.
REQ-033 Only requester 1 valid, len 0 -> grant_idx=1 one cycle after valid, single beat with databus_last[1]=1, databus_ready[0]=0 throughout.
REQ-034 mem_ready toggling 1,0,1,0 during len 1 burst -> exactly 2 beats accepted, grant held, busy=1 until second accepted beat.
REQ-035 len=3 but mem_last on 2nd beat -> burst ends, len_err=1 and stays 1 across later correct bursts.
REQ-036 rst pulse during 2nd beat of len 7 burst -> next cycle mem_valid=0, busy=0, rr_ptr=0; new request from requester 1 served normally.

Source files
------------

// File: rtl/versat_pkg.sv
// Shared definitions for the Versat databus arbiter: datapath width, default
// requester count and the arbiter state encoding.
`ifndef DATAPATH_W
`define DATAPATH_W 32
`endif

package versat_pkg;

    localparam int DATAPATH_W     = `DATAPATH_W;
    localparam int N_REQ_DEF      = 2;
    localparam int AXI_ADDR_W_DEF = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/versat_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// returned both one-hot and as an index.
module versat_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;
    int   cand;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

    assign gnt = found ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/versat_databus_arbiter.sv
// Multiplexes N_REQ VRead/VWrite databus requesters onto one memory port,
// one whole burst at a time, with round-robin fairness between bursts.
module versat_databus_arbiter
    import versat_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int AXI_ADDR_W = AXI_ADDR_W_DEF,
    parameter int DATA_W     = `DATAPATH_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             databus_valid,
    input  logic [N_REQ*AXI_ADDR_W-1:0]  databus_addr,
    input  logic [N_REQ*DATA_W-1:0]      databus_wdata,
    input  logic [N_REQ*DATA_W/8-1:0]    databus_wstrb,
    input  logic [N_REQ*8-1:0]           databus_len,
    output logic [N_REQ-1:0]             databus_ready,
    output logic [N_REQ-1:0]             databus_last,
    output logic [DATA_W-1:0]            databus_rdata,
    output logic                         mem_valid,
    output logic [AXI_ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [DATA_W/8-1:0]          mem_wstrb,
    output logic [7:0]                   mem_len,
    input  logic                         mem_ready,
    input  logic                         mem_last,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         busy,
    output logic [$clog2(N_REQ)-1:0]     grant_idx,
    output logic                         len_err
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    logic [AXI_ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0]     wdata_arr [N_REQ];
    logic [STRB_W-1:0]     wstrb_arr [N_REQ];
    logic [7:0]            len_arr   [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = databus_addr[gi*AXI_ADDR_W +: AXI_ADDR_W];
            assign wdata_arr[gi] = databus_wdata[gi*DATA_W +: DATA_W];
            assign wstrb_arr[gi] = databus_wstrb[gi*STRB_W +: STRB_W];
            assign len_arr[gi]   = databus_len[gi*8 +: 8];
        end
    endgenerate

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [8:0]       cnt_q, cnt_d;
    logic             len_err_q, len_err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             beat_acc;

    versat_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (databus_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign arb_valid = |arb_gnt;
    assign beat_acc  = mem_valid & mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    cnt_d   = {1'b0, len_arr[arb_idx]} + 9'd1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_acc) begin
                    cnt_d = (cnt_q == 9'd0) ? 9'd0 : cnt_q - 9'd1;
                    // Memory's last flag is authoritative; a mismatch with the
                    // requested length is only flagged, never used to cut the burst.
                    if (mem_last) begin
                        if (cnt_q != 9'd1) begin
                            len_err_d = 1'b1;
                        end
                        state_d  = ST_IDLE;
                        rr_ptr_d = IDX_W'(rr_next(int'(grant_q), N_REQ));
                    end else if (cnt_q <= 9'd1) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_valid     = 1'b0;
        mem_addr      = addr_arr[grant_q];
        mem_wdata     = wdata_arr[grant_q];
        mem_wstrb     = wstrb_arr[grant_q];
        mem_len       = len_arr[grant_q];
        databus_ready = '0;
        databus_last  = '0;
        if (state_q == ST_BURST) begin
            mem_valid              = databus_valid[grant_q];
            databus_ready[grant_q] = mem_ready;
            databus_last[grant_q]  = mem_last;
        end
    end

    assign databus_rdata = mem_rdata;
    assign busy          = (state_q == ST_BURST);
    assign grant_idx     = grant_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// Directed bench for versat_databus_arbiter with two requesters: a per-cycle
// vector table for the basic round-robin case plus hand-written corner sequences.
module tb_versat_databus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  databus_valid;
    logic [63:0] databus_addr;
    logic [63:0] databus_wdata;
    logic [7:0]  databus_wstrb;
    logic [15:0] databus_len;
    logic [1:0]  databus_ready;
    logic [1:0]  databus_last;
    logic [31:0] databus_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [7:0]  mem_len;
    logic        mem_ready;
    logic        mem_last;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [0:0]  grant_idx;
    logic        len_err;

    int tests;
    int fails;
    int beats;

    versat_databus_arbiter #(
        .N_REQ      (2),
        .AXI_ADDR_W (32),
        .DATA_W     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .databus_valid (databus_valid),
        .databus_addr  (databus_addr),
        .databus_wdata (databus_wdata),
        .databus_wstrb (databus_wstrb),
        .databus_len   (databus_len),
        .databus_ready (databus_ready),
        .databus_last  (databus_last),
        .databus_rdata (databus_rdata),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_len       (mem_len),
        .mem_ready     (mem_ready),
        .mem_last      (mem_last),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .grant_idx     (grant_idx),
        .len_err       (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  valid;
        logic        mr;
        logic        ml;
        logic        busy;
        logic        grant;
        logic        mv;
        logic [1:0]  rdy;
        logic [1:0]  lst;
        logic [31:0] addr;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic [1:0] v, input logic r, input logic l);
        @(negedge clk);
        rst           = 1'b0;
        databus_valid = v;
        mem_ready     = r;
        mem_last      = l;
        mem_rdata     = $urandom;
        #1;
        $display("[TB] t=%0t valid=%b mr=%b ml=%b busy=%b grant=%0d mv=%b rdy=%b lst=%b err=%b",
                 $time, v, r, l, busy, grant_idx, mem_valid, databus_ready, databus_last, len_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        databus_valid = 2'b00;
        mem_ready     = 1'b0;
        mem_last      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        databus_valid = 2'b00;
        databus_addr  = {32'h0000_2000, 32'h0000_1000};
        databus_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        databus_wstrb = {4'hF, 4'h0};
        databus_len   = {8'd3, 8'd3};
        mem_ready     = 1'b0;
        mem_last      = 1'b0;
        mem_rdata     = '0;

        //            valid  mr    ml    busy  g     mv    rdy    lst    addr          err
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0,        1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 32'h0000_1000, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 32'h0000_1000, 1'b0};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 32'h0000_1000, 1'b0};
        tbl[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 32'h0000_1000, 1'b0};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0,        1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 32'h0000_2000, 1'b0};
        tbl[7]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 32'h0000_2000, 1'b0};
        tbl[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 32'h0000_2000, 1'b0};
        tbl[9]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 32'h0000_2000, 1'b0};
        tbl[10] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0,        1'b0};
        tbl[11] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0,        1'b0};

        do_reset();
        #1;
        chk("reset busy",    32'(busy),          32'h0);
        chk("reset grant",   32'(grant_idx),     32'h0);
        chk("reset len_err", 32'(len_err),       32'h0);
        chk("reset mvalid",  32'(mem_valid),     32'h0);
        chk("reset ready",   32'(databus_ready), 32'h0);
        chk("reset last",    32'(databus_last),  32'h0);

        // Two requesters, len 3 each: 0 then 1, one IDLE cycle between.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].valid, tbl[i].mr, tbl[i].ml);
            chk($sformatf("rr%0d busy", i),  32'(busy),          32'(tbl[i].busy));
            chk($sformatf("rr%0d grant", i), 32'(grant_idx),     32'(tbl[i].grant));
            chk($sformatf("rr%0d mvalid", i), 32'(mem_valid),    32'(tbl[i].mv));
            chk($sformatf("rr%0d ready", i), 32'(databus_ready), 32'(tbl[i].rdy));
            chk($sformatf("rr%0d last", i),  32'(databus_last),  32'(tbl[i].lst));
            chk($sformatf("rr%0d len_err", i), 32'(len_err),     32'(tbl[i].err));
            chk($sformatf("rr%0d rdata", i), databus_rdata,      mem_rdata);
            if (tbl[i].mv) begin
                chk($sformatf("rr%0d addr", i), mem_addr, tbl[i].addr);
            end
        end

        // Single-beat burst from requester 1 only.
        do_reset();
        databus_len = {8'd0, 8'd3};
        step(2'b10, 1'b1, 1'b1);
        chk("single idle busy",  32'(busy),          32'h0);
        chk("single idle last",  32'(databus_last),  32'h0);
        step(2'b10, 1'b1, 1'b1);
        chk("single grant",      32'(grant_idx),     32'h1);
        chk("single mvalid",     32'(mem_valid),     32'h1);
        chk("single ready",      32'(databus_ready), 32'h2);
        chk("single last",       32'(databus_last),  32'h2);
        chk("single mem_len",    32'(mem_len),       32'h0);
        chk("single wdata",      mem_wdata,          32'hBBBB_0001);
        chk("single wstrb",      32'(mem_wstrb),     32'hF);
        step(2'b00, 1'b1, 1'b0);
        chk("single end busy",   32'(busy),          32'h0);
        chk("single end ready",  32'(databus_ready), 32'h0);

        // Len 1 burst with mem_ready toggling 1,0,1,0.
        databus_len = {8'd0, 8'd1};
        beats = 0;
        step(2'b01, 1'b1, 1'b0);
        chk("stall idle busy", 32'(busy), 32'h0);
        step(2'b01, 1'b1, 1'b0);
        if (databus_ready[0]) beats++;
        chk("stall b1 busy",  32'(busy),          32'h1);
        chk("stall b1 ready", 32'(databus_ready), 32'h1);
        step(2'b01, 1'b0, 1'b0);
        if (databus_ready[0]) beats++;
        chk("stall gap busy",  32'(busy),          32'h1);
        chk("stall gap grant", 32'(grant_idx),     32'h0);
        chk("stall gap ready", 32'(databus_ready), 32'h0);
        step(2'b01, 1'b1, 1'b1);
        if (databus_ready[0]) beats++;
        chk("stall b2 busy", 32'(busy),         32'h1);
        chk("stall b2 last", 32'(databus_last), 32'h1);
        step(2'b00, 1'b0, 1'b0);
        if (databus_ready[0]) beats++;
        chk("stall end busy",  32'(busy),    32'h0);
        chk("stall beats",     32'(beats),   32'h2);
        chk("stall len_err",   32'(len_err), 32'h0);

        // Early mem_last on a len 3 burst, then a correct burst keeps the sticky flag.
        databus_len = {8'd0, 8'd3};
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        chk("early b1 grant", 32'(grant_idx), 32'h0);
        step(2'b01, 1'b1, 1'b1);
        chk("early b2 last",    32'(databus_last), 32'h1);
        chk("early b2 len_err", 32'(len_err),      32'h0);
        step(2'b00, 1'b0, 1'b0);
        chk("early end busy",    32'(busy),    32'h0);
        chk("early end len_err", 32'(len_err), 32'h1);
        step(2'b10, 1'b1, 1'b1);
        step(2'b10, 1'b1, 1'b1);
        chk("after grant", 32'(grant_idx),    32'h1);
        chk("after last",  32'(databus_last), 32'h2);
        step(2'b00, 1'b0, 1'b0);
        chk("after len_err", 32'(len_err), 32'h1);

        // Reset in the middle of a len 7 burst, then requester 1 served normally.
        databus_len = {8'd1, 8'd7};
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        chk("abort b1 ready", 32'(databus_ready), 32'h1);
        step(2'b01, 1'b1, 1'b0);
        chk("abort b2 busy",  32'(busy),          32'h1);
        chk("abort b2 ready", 32'(databus_ready), 32'h1);
        rst = 1'b1;
        step(2'b10, 1'b1, 1'b0);
        chk("abort mvalid",  32'(mem_valid),     32'h0);
        chk("abort busy",    32'(busy),          32'h0);
        chk("abort ready",   32'(databus_ready), 32'h0);
        chk("abort len_err", 32'(len_err),       32'h0);
        chk("abort rr_ptr",  32'(dut.rr_ptr_q),  32'h0);
        step(2'b10, 1'b1, 1'b0);
        chk("resume grant", 32'(grant_idx),     32'h1);
        chk("resume ready", 32'(databus_ready), 32'h2);
        chk("resume len",   32'(mem_len),       32'h1);
        chk("resume addr",  mem_addr,           32'h0000_2000);
        step(2'b10, 1'b1, 1'b1);
        chk("resume last",  32'(databus_last),  32'h2);
        step(2'b00, 1'b0, 1'b0);
        chk("resume end busy",    32'(busy),    32'h0);
        chk("resume end len_err", 32'(len_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
